// File: rtl/cb_seg_pkg.sv
// Shared definitions for the code block segmentation / CRC attachment chain.
//   CRC24A_POLY, CRC24B_POLY : generator polynomials without the x^24 term
//   CRC_LEN                  : code block CRC length in bits
//   attach_state_t           : CRC attachment FSM states
package cb_seg_pkg;

    localparam int unsigned CRC_LEN     = 24;
    localparam logic [23:0] CRC24A_POLY = 24'h864CFB;
    localparam logic [23:0] CRC24B_POLY = 24'h800063;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCrco
    } attach_state_t;

endpackage

// File: rtl/crc24_lfsr.sv
// Serial CRC LFSR (MSB-first, Galois form).
//   clk, reset : clock, asynchronous active-high reset (state <- INIT)
//   init       : use INIT as the prior state for this cycle
//   shift_en   : advance the register by one bit
//   d          : message bit folded in when out_mode = 0
//   out_mode   : plain left shift with zero fill (CRC read-out)
//   state      : current register contents
module crc24_lfsr
    import cb_seg_pkg::*;
#(
    parameter int unsigned         W    = CRC_LEN,
    parameter logic [W-1:0]        POLY = CRC24B_POLY,
    parameter logic [W-1:0]        INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         shift_en,
    input  logic         d,
    input  logic         out_mode,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q, state_d;
    logic [W-1:0] prior;

    always_comb begin
        prior   = init ? INIT : state_q;
        state_d = prior;
        if (shift_en) begin
            if (out_mode) begin
                state_d = {prior[W-2:0], 1'b0};
            end else begin
                state_d = {prior[W-2:0], 1'b0} ^ ((d ^ prior[W-1]) ? POLY : '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/cb_crc24b_attach.sv
// Serial CRC24B attachment: computes the CRC over data/filler bits of each code
// block and writes it into the reserved CRC slot bits, MSB first. One cycle
// of registered latency; input gaps are reproduced on the output.
//   clk, reset                                  : clock, async active-high reset
//   in_valid/in_data/in_start/in_filling/in_crc : serial input bit and flags
//   out_valid/out_data/out_start/out_filling/out_crc : serial output bit and flags
//   blk_done : pulse with the last CRC bit out
//   err      : pulse on a protocol violation
module cb_crc24b_attach
    import cb_seg_pkg::*;
#(
    parameter int unsigned         CRC_W = CRC_LEN,
    parameter logic [CRC_W-1:0]    POLY  = CRC24B_POLY,
    parameter logic [CRC_W-1:0]    INIT  = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_data,
    input  logic in_start,
    input  logic in_filling,
    input  logic in_crc,
    output logic out_valid,
    output logic out_data,
    output logic out_start,
    output logic out_filling,
    output logic out_crc,
    output logic blk_done,
    output logic err
);

    attach_state_t state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CRC_W-1:0] lfsr;
    logic             lfsr_init, lfsr_shift, lfsr_out_mode, msg_bit;
    logic             data_d, start_d, fill_d, crc_d, done_d, err_d;
    logic             unused_lfsr;

    assign msg_bit     = in_data & ~in_filling;
    assign unused_lfsr = ^lfsr[CRC_W-2:0];

    crc24_lfsr #(
        .W    (CRC_W),
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .init     (lfsr_init),
        .shift_en (lfsr_shift),
        .d        (msg_bit),
        .out_mode (lfsr_out_mode),
        .state    (lfsr)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lfsr_init     = 1'b0;
        lfsr_shift    = 1'b0;
        lfsr_out_mode = 1'b0;
        data_d        = 1'b0;
        start_d       = 1'b0;
        fill_d        = 1'b0;
        crc_d         = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        if (in_valid) begin
            data_d = msg_bit;
            fill_d = in_filling;
            if (in_start) begin
                // A start always wins; it is only an error when it cuts a CRC
                // short or coincides with a CRC slot flag.
                lfsr_init  = 1'b1;
                lfsr_shift = 1'b1;
                start_d    = 1'b1;
                cnt_d      = '0;
                state_d    = StData;
                err_d      = in_crc | (state_q == StCrco);
            end else begin
                unique case (state_q)
                    StIdle: begin
                        err_d = 1'b1;
                    end
                    StData, StCrco: begin
                        if (in_crc) begin
                            lfsr_shift    = 1'b1;
                            lfsr_out_mode = 1'b1;
                            data_d        = lfsr[CRC_W-1];
                            fill_d        = 1'b0;
                            crc_d         = 1'b1;
                            if (cnt_q == 5'(CRC_W - 1)) begin
                                done_d  = 1'b1;
                                cnt_d   = '0;
                                state_d = StIdle;
                            end else begin
                                cnt_d   = cnt_q + 5'd1;
                                state_d = StCrco;
                            end
                        end else if (state_q == StData) begin
                            lfsr_shift = 1'b1;
                        end else begin
                            // CRC cut short by a data bit: pass it through, drop the rest.
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            out_start   <= 1'b0;
            out_filling <= 1'b0;
            out_crc     <= 1'b0;
            blk_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid   <= in_valid;
            out_data    <= data_d;
            out_start   <= start_d;
            out_filling <= fill_d;
            out_crc     <= crc_d;
            blk_done    <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_cb_crc24b_attach.sv
module tb_cb_crc24b_attach;
    import cb_seg_pkg::*;

    // Expected output flags: data, start, filling, crc, done, err
    typedef struct packed {
        logic d;
        logic s;
        logic f;
        logic c;
        logic done;
        logic err;
    } exp_t;

    typedef struct packed {
        logic v;
        logic d;
        logic s;
        logic f;
        logic c;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_data = 1'b0, in_start = 1'b0, in_filling = 1'b0, in_crc = 1'b0;
    logic out_valid, out_data, out_start, out_filling, out_crc, blk_done, err;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic exp_v;

    always #5 clk = ~clk;

    cb_crc24b_attach dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_start    (in_start),
        .in_filling  (in_filling),
        .in_crc      (in_crc),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_start   (out_start),
        .out_filling (out_filling),
        .out_crc     (out_crc),
        .blk_done    (blk_done),
        .err         (err)
    );

    // Bench-side view of which cycles must carry an output bit.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_v <= 1'b0;
        else       exp_v <= in_valid;
    end

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (out_valid !== exp_v) begin
                bad++;
                $display("FAIL out_valid timing: got %b want %b at %0t", out_valid, exp_v, $time);
            end
            if (out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_bit: got d=%b with empty scoreboard at %0t",
                             out_data, $time);
                end else begin
                    exp_t e;
                    exp_t g;
                    e = exp_q.pop_front();
                    g = '{d: out_data, s: out_start, f: out_filling, c: out_crc,
                          done: blk_done, err: err};
                    if (g !== e) begin
                        bad++;
                        $display("FAIL out_bit: got dsfc/done/err=%b want %b at %0t", g, e, $time);
                    end
                end
            end
        end
    end

    task automatic send(input logic v, input logic d, input logic s, input logic f,
                        input logic c, input exp_t e);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        in_start   = s;
        in_filling = f;
        in_crc     = c;
        if (v) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic gap(input bit gaps);
        if (gaps) idle(int'($urandom_range(0, 2)));
    endtask

    // CRC by long division of M(x)*x^24 by the full generator (zero init).
    function automatic logic [23:0] crc_ref(input logic [63:0] bits, input int n,
                                            input logic [63:0] fill);
        logic [24:0] gen;
        logic [24:0] rem;
        logic b;
        gen = {1'b1, CRC24B_POLY};
        rem = '0;
        for (int i = 0; i < n + 24; i++) begin
            b   = (i < n) ? (bits[i] & ~fill[i]) : 1'b0;
            rem = {rem[23:0], b};
            if (rem[24]) rem = rem ^ gen;
        end
        return rem[23:0];
    endfunction

    // Data/filler bits (bit 0 first), then ncrc CRC slot bits carrying random in_data.
    task automatic send_block(input logic [63:0] bits, input int n, input logic [63:0] fill,
                              input logic [23:0] crc, input int ncrc, input bit gaps);
        for (int i = 0; i < n; i++) begin
            gap(gaps);
            send(1'b1, bits[i], i == 0, fill[i], 1'b0,
                 '{d: bits[i] & ~fill[i], s: i == 0, f: fill[i], c: 1'b0, done: 1'b0, err: 1'b0});
        end
        for (int j = 0; j < ncrc; j++) begin
            gap(gaps);
            send(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1,
                 '{d: crc[23-j], s: 1'b0, f: 1'b0, c: 1'b1, done: j == 23, err: 1'b0});
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({out_valid, out_data, out_start, out_filling, out_crc, blk_done, err} !== 7'b0) begin
            bad++;
            $display("FAIL %s: got outputs=%b want 0000000", name,
                     {out_valid, out_data, out_start, out_filling, out_crc, blk_done, err});
        end
    endtask

    vec_t tbl[13];

    initial begin
        logic [63:0] rbits;
        logic [23:0] rcrc;

        // in: v d s f c | out: d s f c done err
        tbl[0]  = {5'b11000, 6'b100001};  // idle bit without start
        tbl[1]  = {5'b10010, 6'b001001};  // idle filler without start
        tbl[2]  = {5'b00000, 6'b000000};  // gap
        tbl[3]  = {5'b11101, 6'b110001};  // start + crc together: start, err
        tbl[4]  = {5'b10001, 6'b100100};  // first CRC bit = MSB of 0x800063
        tbl[5]  = {5'b11000, 6'b100001};  // data inside CRC: passed, err, to idle
        tbl[6]  = {5'b11000, 6'b100001};  // back in idle
        tbl[7]  = {5'b10100, 6'b010000};  // start with data 0
        tbl[8]  = {5'b11000, 6'b100000};  // data 1
        tbl[9]  = {5'b11100, 6'b110000};  // restart mid-data: no err
        tbl[10] = {5'b10001, 6'b100100};  // CRC bit 1
        tbl[11] = {5'b10100, 6'b010001};  // start during CRC: err
        tbl[12] = {5'b10100, 6'b010000};  // start during data (C=1 end): no err

        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset_state");
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            send(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].e);
        end

        // Single data bit 1 -> CRC 0x800063.
        send_block(64'h1, 1, 64'h0, 24'h800063, 24, 1'b0);
        idle(2);
        // Bits 1,0 with random gaps -> 0x8000A5.
        send_block(64'h1, 2, 64'h0, 24'h8000A5, 24, 1'b1);
        idle(2);
        // Eight fillers (data 1) then data 1 -> fillers count as zero.
        send_block(64'h1FF, 9, 64'hFF, 24'h800063, 24, 1'b1);
        // Back-to-back: second start right after the 24th CRC bit.
        rbits = {$urandom, $urandom};
        rcrc  = crc_ref(rbits, 40, 64'h0);
        send_block(64'h1, 2, 64'h0, 24'h8000A5, 24, 1'b0);
        send_block(rbits, 40, 64'h0, rcrc, 24, 1'b0);
        idle(2);
        // CRC slot run cut after 10 bits.
        send_block(64'h1, 1, 64'h0, 24'h800063, 10, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
             '{d: 1'b1, s: 1'b0, f: 1'b0, c: 1'b0, done: 1'b0, err: 1'b1});
        send_block(64'h1, 2, 64'h0, 24'h8000A5, 24, 1'b0);
        idle(2);

        // Reset mid-data, then a fresh block.
        send_block(64'h15, 5, 64'h0, 24'h0, 0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 reset = 1'b1;
        #1 check_outputs_zero("async_reset_mid_block");
        exp_q.delete();
        @(negedge clk) reset = 1'b0;
        rbits = {$urandom, $urandom};
        rcrc  = crc_ref(rbits, 33, 64'h0);
        send_block(rbits, 33, 64'h0, rcrc, 24, 1'b1);
        idle(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d bits still expected, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
